// File: rtl/exec_pkg.sv
// exec_pkg -- shared definitions for the exec_ctrl instruction controller.
//   opcode_t : instruction opcodes (A-E are undefined and retire as illegal)
//   state_t  : controller FSM states
//   *_MSB/*_LSB : bit positions of the instruction fields
//   Helpers classify opcodes by their side effects.
package exec_pkg;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 8;
  localparam int RS1_MSB = 7;
  localparam int RS1_LSB = 4;
  localparam int RS2_MSB = 3;
  localparam int RS2_LSB = 0;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_ADD  = 4'h1,
    OP_SUB  = 4'h2,
    OP_AND  = 4'h3,
    OP_OR   = 4'h4,
    OP_XOR  = 4'h5,
    OP_MOV  = 4'h6,
    OP_LDI  = 4'h7,
    OP_SHL  = 4'h8,
    OP_SHR  = 4'h9,
    OP_HALT = 4'hF
  } opcode_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECODE,
    ST_EXEC,
    ST_WB,
    ST_HALT
  } state_t;

  // Opcodes whose result updates flag_z / flag_c.
  function automatic logic sets_flags(input opcode_t op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Opcodes that write rd in the write-back cycle.
  function automatic logic writes_rd(input opcode_t op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
      OP_MOV, OP_LDI, OP_SHL, OP_SHR: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_illegal(input logic [3:0] op);
    return (op >= 4'hA) && (op <= 4'hE);
  endfunction

endpackage

// File: rtl/exec_alu.sv
// exec_alu -- purely combinational ALU for exec_ctrl.
//   op     : opcode of the instruction being executed
//   a, b   : register operands (rs1, rs2)
//   imm    : 8-bit immediate, zero-extended for LDI
//   result : DW-bit result, wrapping modulo 2^DW
//   carry  : carry-out (ADD), borrow (SUB), shifted-out bit (SHL/SHR), else 0
module exec_alu
  import exec_pkg::*;
#(
  parameter int DW = 16
) (
  input  opcode_t         op,
  input  logic [DW-1:0]   a,
  input  logic [DW-1:0]   b,
  input  logic [7:0]      imm,
  output logic [DW-1:0]   result,
  output logic            carry
);

  // One extra bit so the carry/borrow falls out of the sum directly.
  logic [DW:0] sum;

  always_comb begin
    sum    = '0;
    result = '0;
    carry  = 1'b0;
    case (op)
      OP_ADD: begin
        sum    = {1'b0, a} + {1'b0, b};
        result = sum[DW-1:0];
        carry  = sum[DW];
      end
      OP_SUB: begin
        // Top bit of the widened difference is set exactly when a < b.
        sum    = {1'b0, a} - {1'b0, b};
        result = sum[DW-1:0];
        carry  = sum[DW];
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_MOV: result = a;
      OP_LDI: result = {{(DW-8){1'b0}}, imm};
      OP_SHL: begin
        result = {a[DW-2:0], 1'b0};
        carry  = a[DW-1];
      end
      OP_SHR: begin
        result = {1'b0, a[DW-1:1]};
        carry  = a[0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/exec_ctrl.sv
// exec_ctrl -- multi-cycle instruction controller driving an external
// register file (IDLE -> DECODE -> EXEC -> WB, or EXEC -> HALT).
//   clk, rst (async, active low)
//   instr/instr_valid/instr_ready : instruction handshake
//   clr                           : clear request (honoured in IDLE or HALT)
//   rf_rst                        : one-cycle clear strobe to the register file
//   rf_we/rf_addr_wr/rf_data_in   : register-file write port
//   rf_addr_rd1/2, rf_data_out1/2 : register-file read ports (combinational data)
//   done/illegal                  : retire pulse, plus undefined-opcode marker
//   halted/flag_z/flag_c          : status
module exec_ctrl
  import exec_pkg::*;
#(
  parameter int DW = 16,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] instr,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic          clr,
  output logic          rf_rst,
  output logic          rf_we,
  output logic [AW-1:0] rf_addr_wr,
  output logic [DW-1:0] rf_data_in,
  output logic [AW-1:0] rf_addr_rd1,
  output logic [AW-1:0] rf_addr_rd2,
  input  logic [DW-1:0] rf_data_out1,
  input  logic [DW-1:0] rf_data_out2,
  output logic          done,
  output logic          illegal,
  output logic          halted,
  output logic          flag_z,
  output logic          flag_c
);

  state_t        state_reg, state_next;
  logic [DW-1:0] instr_reg;
  logic [DW-1:0] result_reg;
  logic          flag_z_reg, flag_c_reg;
  logic          halt_entry_reg;   // first cycle in HALT, carries the done pulse

  logic [3:0]    op_bits;
  opcode_t       op;
  logic [DW-1:0] alu_result;
  logic          alu_carry;
  logic          accept;

  assign op_bits = instr_reg[OPC_MSB:OPC_LSB];
  assign op      = opcode_t'(op_bits);
  assign accept  = instr_valid && instr_ready;

  // Addresses come straight from the latched instruction, so they are stable
  // from DECODE through EXEC; rd is only written back in WB, which is why an
  // instruction reading its own destination sees the old value.
  assign rf_addr_rd1 = AW'(instr_reg[RS1_MSB:RS1_LSB]);
  assign rf_addr_rd2 = AW'(instr_reg[RS2_MSB:RS2_LSB]);
  assign rf_addr_wr  = AW'(instr_reg[RD_MSB:RD_LSB]);
  assign rf_data_in  = result_reg;
  assign flag_z      = flag_z_reg;
  assign flag_c      = flag_c_reg;

  exec_alu #(.DW(DW)) u_alu (
    .op     (op),
    .a      (rf_data_out1),
    .b      (rf_data_out2),
    .imm    (instr_reg[IMM_MSB:IMM_LSB]),
    .result (alu_result),
    .carry  (alu_carry)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= ST_IDLE;
      instr_reg      <= '0;
      result_reg     <= '0;
      flag_z_reg     <= 1'b0;
      flag_c_reg     <= 1'b0;
      halt_entry_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      halt_entry_reg <= (state_reg == ST_EXEC) && (op == OP_HALT);
      if (accept) begin
        instr_reg <= instr;
      end
      if (state_reg == ST_EXEC) begin
        result_reg <= alu_result;
        if (sets_flags(op)) begin
          flag_z_reg <= (alu_result == '0);
          flag_c_reg <= alu_carry;
        end
      end
      // rf_rst is only raised for a clr honoured in IDLE/HALT, never in EXEC,
      // so this cannot collide with the flag update above.
      if (rf_rst) begin
        flag_z_reg <= 1'b0;
        flag_c_reg <= 1'b0;
      end
    end
  end

  always_comb begin
    state_next  = state_reg;
    instr_ready = 1'b0;
    rf_rst      = 1'b0;
    rf_we       = 1'b0;
    done        = 1'b0;
    illegal     = 1'b0;
    halted      = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        // rst gating keeps both strobes low while the controller is held in reset.
        instr_ready = rst && !clr;
        if (clr) begin
          rf_rst = rst;
        end else if (instr_valid) begin
          state_next = ST_DECODE;
        end
      end
      ST_DECODE: state_next = ST_EXEC;
      ST_EXEC:   state_next = (op == OP_HALT) ? ST_HALT : ST_WB;
      ST_WB: begin
        rf_we      = writes_rd(op);
        done       = 1'b1;
        illegal    = is_illegal(op_bits);
        state_next = ST_IDLE;
      end
      ST_HALT: begin
        halted = 1'b1;
        done   = halt_entry_reg;
        if (clr) begin
          rf_rst     = rst;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_exec_ctrl.sv
// tb_exec_ctrl -- scoreboard bench for exec_ctrl with a behavioural register
// file and an instruction-level reference model.
module tb_exec_ctrl;

  localparam int DW = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] instr;
  logic          instr_valid;
  logic          instr_ready;
  logic          clr;
  logic          rf_rst;
  logic          rf_we;
  logic [AW-1:0] rf_addr_wr;
  logic [DW-1:0] rf_data_in;
  logic [AW-1:0] rf_addr_rd1;
  logic [AW-1:0] rf_addr_rd2;
  logic [DW-1:0] rf_data_out1;
  logic [DW-1:0] rf_data_out2;
  logic          done;
  logic          illegal;
  logic          halted;
  logic          flag_z;
  logic          flag_c;

  always #5 clk = ~clk;

  exec_ctrl #(.DW(DW), .AW(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .clr          (clr),
    .rf_rst       (rf_rst),
    .rf_we        (rf_we),
    .rf_addr_wr   (rf_addr_wr),
    .rf_data_in   (rf_data_in),
    .rf_addr_rd1  (rf_addr_rd1),
    .rf_addr_rd2  (rf_addr_rd2),
    .rf_data_out1 (rf_data_out1),
    .rf_data_out2 (rf_data_out2),
    .done         (done),
    .illegal      (illegal),
    .halted       (halted),
    .flag_z       (flag_z),
    .flag_c       (flag_c)
  );

  // Behavioural register file: combinational read, write/clear on the clock.
  logic [15:0] rf [16];
  always @(posedge clk) begin
    if (rf_rst) begin
      for (int i = 0; i < 16; i++) rf[i] <= 16'h0;
    end else if (rf_we) begin
      rf[rf_addr_wr] <= rf_data_in;
    end
  end
  assign rf_data_out1 = rf[rf_addr_rd1];
  assign rf_data_out2 = rf[rf_addr_rd2];

  typedef struct packed {
    logic        we;
    logic [3:0]  addr;
    logic [15:0] data;
    logic        ill;
    logic        z;
    logic        c;
    logic        h;
  } resp_t;

  resp_t exp_q[$];
  int    acc_q[$];
  int    n_cmp = 0;
  int    n_err = 0;
  int    nc    = 0;

  // Reference model state (architectural view only).
  logic [15:0] mregs [16];
  logic        mz, mc, mh;

  // Monitor: records acceptances and scores every retire against the queue.
  always @(negedge clk) begin : monitor
    resp_t obs, e;
    int    lat;
    nc++;
    if (rst) begin
      if (instr_valid && instr_ready) acc_q.push_back(nc);
      if (done) begin
        obs = {rf_we, rf_we ? rf_addr_wr : 4'h0, rf_we ? rf_data_in : 16'h0,
               illegal, flag_z, flag_c, halted};
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_done got=%h required=none", obs);
        end else begin
          e = exp_q.pop_front();
          if (obs !== e) begin
            n_err++;
            $display("FAIL retire got we=%b a=%h d=%h ill=%b z=%b c=%b h=%b required we=%b a=%h d=%h ill=%b z=%b c=%b h=%b",
                     obs.we, obs.addr, obs.data, obs.ill, obs.z, obs.c, obs.h,
                     e.we, e.addr, e.data, e.ill, e.z, e.c, e.h);
          end
        end
        n_cmp++;
        if (acc_q.size() == 0) begin
          n_err++;
          $display("FAIL latency got=no_accept required=3");
        end else begin
          lat = nc - acc_q.pop_front();
          if (lat != 3) begin
            n_err++;
            $display("FAIL latency got=%0d required=3", lat);
          end
        end
      end
      if ((rf_we || illegal) && !done) begin
        n_cmp++;
        n_err++;
        $display("FAIL strobe_without_done got we=%b ill=%b required=0", rf_we, illegal);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
    n_cmp++;
    if (got !== req) begin
      n_err++;
      $display("FAIL %s got=%h required=%h", name, got, req);
    end
  endtask

  function automatic logic [15:0] mk(input logic [3:0] op, input logic [3:0] rd,
                                     input logic [3:0] rs1, input logic [3:0] rs2);
    return {op, rd, rs1, rs2};
  endfunction

  function automatic logic [15:0] ldi(input logic [3:0] rd, input logic [7:0] imm);
    return {4'h7, rd, imm};
  endfunction

  // Instruction-level model: compute the retire response and update state.
  task automatic model_issue(input logic [15:0] ins);
    logic [3:0]  op, rd;
    int unsigned a, b, r;
    bit          wr, fl, ill, cy;
    resp_t       e;
    op = ins[15:12];
    rd = ins[11:8];
    a  = mregs[ins[7:4]];
    b  = mregs[ins[3:0]];
    r  = 0; wr = 0; fl = 0; ill = 0; cy = 0;
    case (op)
      4'h0: ;
      4'h1: begin r = a + b; cy = (r > 65535); r = r % 65536; wr = 1; fl = 1; end
      4'h2: begin r = (a + 65536 - b) % 65536; cy = (a < b); wr = 1; fl = 1; end
      4'h3: begin r = a & b; wr = 1; fl = 1; end
      4'h4: begin r = a | b; wr = 1; fl = 1; end
      4'h5: begin r = a ^ b; wr = 1; fl = 1; end
      4'h6: begin r = a; wr = 1; end
      4'h7: begin r = ins[7:0]; wr = 1; end
      4'h8: begin r = (a * 2) % 65536; cy = (a >= 32768); wr = 1; fl = 1; end
      4'h9: begin r = a / 2; cy = (a % 2 == 1); wr = 1; fl = 1; end
      4'hF: mh = 1'b1;
      default: ill = 1;
    endcase
    if (fl) begin
      mz = (r == 0);
      mc = cy;
    end
    if (wr) mregs[rd] = r[15:0];
    e.we   = wr;
    e.addr = wr ? rd : 4'h0;
    e.data = wr ? r[15:0] : 16'h0;
    e.ill  = ill;
    e.z    = mz;
    e.c    = mc;
    e.h    = mh;
    exp_q.push_back(e);
  endtask

  // Present an instruction until accepted (bounded); returns at posedge+1.
  task automatic issue(input logic [15:0] ins);
    bit got;
    got = 0;
    instr = ins;
    instr_valid = 1'b1;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (instr_ready) begin
        got = 1;
        model_issue(ins);
      end
    end
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    $display("txn instr=%h accepted=%0d", ins, got);
    if (!got) begin
      n_cmp++;
      n_err++;
      $display("FAIL accept_timeout got=not_ready required=ready");
    end
  endtask

  task automatic drain;
    bit ok;
    ok = 0;
    for (int k = 0; k < 12; k++) begin
      if (exp_q.size() == 0) begin
        ok = 1;
        break;
      end
      tick();
    end
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL done_timeout got=pending%0d required=0", exp_q.size());
      exp_q.delete();
      acc_q.delete();
    end
  endtask

  task automatic exec(input logic [15:0] ins);
    issue(ins);
    drain();
  endtask

  task automatic do_clr;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int i = 0; i < 16; i++) mregs[i] = 16'h0;
    mz = 0; mc = 0; mh = 0;
  endtask

  task automatic check_all_regs(input string name);
    for (int i = 0; i < 16; i++) check(name, {48'h0, rf[i]}, {48'h0, mregs[i]});
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog got=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [15:0] saved [16];
    logic [3:0]  op;
    rst = 1'b0; clr = 1'b1; instr_valid = 1'b1; instr = 16'h7155;
    mz = 0; mc = 0; mh = 0;
    repeat (3) @(negedge clk);
    // Held in reset with clr and instr_valid high: every output must be zero.
    check("reset_outputs",
          {28'h0, instr_ready, rf_rst, rf_we, done, illegal, halted, flag_z, flag_c,
           rf_addr_wr, rf_addr_rd1, rf_addr_rd2, rf_data_in}, 64'h0);
    tick();
    clr = 1'b0; instr_valid = 1'b0;
    tick();
    rst = 1'b1;
    @(negedge clk);
    check("ready_after_reset", {63'h0, instr_ready}, 64'h1);
    tick();

    // clr and instr_valid together in IDLE: clr wins.
    clr = 1'b1; instr_valid = 1'b1; instr = ldi(4'h1, 8'h55);
    @(negedge clk);
    check("clr_rf_rst", {62'h0, rf_rst, instr_ready}, 64'h2);
    tick();
    clr = 1'b0; instr_valid = 1'b0;
    for (int i = 0; i < 16; i++) mregs[i] = 16'h0;
    @(negedge clk);
    check("rf_rst_one_cycle", {63'h0, rf_rst}, 64'h0);
    check("clr_no_accept_r1", {48'h0, rf[1]}, 64'h0);
    tick();

    // Basic arithmetic.
    exec(ldi(4'h1, 8'h05));
    exec(ldi(4'h2, 8'h03));
    exec(mk(4'h1, 4'h3, 4'h1, 4'h2));
    check("add_r3", {48'h0, rf[3]}, 64'h0008);
    check("add_flags", {62'h0, flag_z, flag_c}, 64'h0);
    exec(mk(4'h2, 4'h5, 4'h2, 4'h1));
    check("sub_r5", {48'h0, rf[5]}, 64'hFFFE);
    check("sub_borrow", {63'h0, flag_c}, 64'h1);

    // Shift to the top bit then overflow the adder.
    exec(ldi(4'h1, 8'hFF));
    for (int k = 0; k < 20 && mregs[1] != 16'h8000; k++) exec(mk(4'h8, 4'h1, 4'h1, 4'h0));
    check("shl_r1", {48'h0, rf[1]}, 64'h8000);
    exec(mk(4'h1, 4'h4, 4'h1, 4'h1));
    check("add_wrap_r4", {48'h0, rf[4]}, 64'h0);
    check("add_wrap_flags", {62'h0, flag_z, flag_c}, 64'h3);

    // Undefined opcode retires with illegal and no write.
    exec(mk(4'hB, 4'h3, 4'h1, 4'h2));
    check_all_regs("illegal_regs");

    // clr during DECODE/EXEC/WB is ignored.
    issue(mk(4'h1, 4'h6, 4'h3, 4'h3));
    clr = 1'b1;
    tick();
    tick();
    clr = 1'b0;
    drain();
    check("clr_ignored_r6", {48'h0, rf[6]}, 64'h0010);
    check("clr_ignored_r3", {48'h0, rf[3]}, 64'h0008);

    // Reset in EXEC aborts the instruction; registers survive.
    for (int i = 0; i < 16; i++) saved[i] = mregs[i];
    issue(mk(4'h1, 4'h7, 4'h1, 4'h3));
    tick();
    rst = 1'b0;
    exp_q.delete();
    acc_q.delete();
    for (int i = 0; i < 16; i++) mregs[i] = saved[i];
    mz = 0; mc = 0; mh = 0;
    @(negedge clk);
    check("abort_no_we_done", {61'h0, rf_we, done, rf_rst}, 64'h0);
    tick();
    rst = 1'b1;
    @(negedge clk);
    check("abort_idle", {61'h0, instr_ready, flag_z, flag_c}, 64'h4);
    check_all_regs("abort_regs");
    tick();

    // HALT holds off new instructions until clr.
    exec(16'hF000);
    instr_valid = 1'b1; instr = ldi(4'h2, 8'h77);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("halt_hold", {62'h0, instr_ready, halted}, 64'h1);
    end
    tick();
    clr = 1'b1;
    @(negedge clk);
    check("halt_clr_rf_rst", {63'h0, rf_rst}, 64'h1);
    tick();
    clr = 1'b0; instr_valid = 1'b0;
    for (int i = 0; i < 16; i++) mregs[i] = 16'h0;
    mz = 0; mc = 0; mh = 0;
    @(negedge clk);
    check("halt_cleared", {61'h0, halted, flag_z, flag_c}, 64'h0);
    check_all_regs("halt_clr_regs");
    tick();

    // Randomized instruction stream against the model.
    for (int k = 0; k < 16; k++) exec(ldi(k[3:0], 8'($urandom)));
    for (int n = 0; n < 80; n++) begin
      op = 4'($urandom_range(0, 15));
      exec({op, 12'($urandom)});
      if (op == 4'hF) do_clr();
    end
    check_all_regs("random_regs");
    check("random_flags", {62'h0, flag_z, flag_c}, {62'h0, mz, mc});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
